// File: rtl/accel_pkg.sv
// Shared register map, bit positions and FSM state type for the Avalon
// multiply accelerator.
package accel_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_OP_A   = 3'd2;
  localparam logic [2:0] ADDR_OP_B   = 3'd3;
  localparam logic [2:0] ADDR_RES_LO = 3'd4;
  localparam logic [2:0] ADDR_RES_HI = 3'd5;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  typedef enum logic {
    IDLE,
    RUN
  } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier: one multiplier bit per clock,
// start/busy/done handshake, product held until the next start.
module seq_multiplier
  import accel_pkg::*;
#(
  parameter int unsigned OP_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              clr_done_i,
  input  logic [OP_W-1:0]   op_a_i,
  input  logic [OP_W-1:0]   op_b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2*OP_W-1:0] product_o
);

  localparam int unsigned PROD_W = 2 * OP_W;
  localparam int unsigned CNT_W  = $clog2(OP_W);

  mul_state_t        state_q, state_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [OP_W-1:0]   mplier_q, mplier_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PROD_W-1:0] sum;

  // Next-state logic: the multiplicand is pre-shifted each cycle so the
  // accumulator add needs no barrel shifter.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    sum      = acc_q + (mplier_q[0] ? mcand_q : '0);

    if (clr_done_i) begin
      done_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          mcand_d  = PROD_W'(op_a_i);
          mplier_d = op_b_i;
          acc_d    = '0;
          prod_d   = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(OP_W - 1)) begin
          prod_d  = sum;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = prod_q;

endmodule

// File: rtl/avalon_mul_accel.sv
// Avalon-MM slave wrapper: operand/control registers, 1-cycle read mux and
// registered level interrupt around seq_multiplier.
module avalon_mul_accel
  import accel_pkg::*;
#(
  parameter int unsigned OP_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        irq
);

  localparam int unsigned PROD_W = 2 * OP_W;

  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
  logic [BUS_W-1:0]  readdata_q, readdata_d;
  logic              start_c;
  logic              clr_done_c;
  logic              mul_busy;
  logic              mul_done;
  logic [PROD_W-1:0] product;
  logic [63:0]       product_ext;

  assign start_c    = avs_write && (avs_address == ADDR_CTRL)
                      && avs_writedata[CTRL_START_BIT];
  assign clr_done_c = avs_write && (avs_address == ADDR_STATUS)
                      && avs_writedata[STATUS_DONE_BIT];
  assign product_ext = 64'(product);

  seq_multiplier #(
    .OP_W(OP_W)
  ) u_mul (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_c),
    .clr_done_i (clr_done_c),
    .op_a_i     (op_a_q),
    .op_b_i     (op_b_q),
    .busy_o     (mul_busy),
    .done_o     (mul_done),
    .product_o  (product)
  );

  // Register writes and read mux; operands are frozen while a multiply runs.
  always_comb begin
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    irq_en_d   = irq_en_q;
    readdata_d = '0;
    irq_d      = mul_done & irq_en_q;

    if (avs_write) begin
      case (avs_address)
        ADDR_CTRL: irq_en_d = avs_writedata[CTRL_IRQ_EN_BIT];
        ADDR_OP_A: if (!mul_busy) op_a_d = avs_writedata[OP_W-1:0];
        ADDR_OP_B: if (!mul_busy) op_b_d = avs_writedata[OP_W-1:0];
        default:   ;
      endcase
    end

    if (avs_read) begin
      case (avs_address)
        ADDR_CTRL:   readdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
        ADDR_STATUS: begin
          readdata_d[STATUS_BUSY_BIT] = mul_busy;
          readdata_d[STATUS_DONE_BIT] = mul_done;
        end
        ADDR_OP_A:   readdata_d = BUS_W'(op_a_q);
        ADDR_OP_B:   readdata_d = BUS_W'(op_b_q);
        ADDR_RES_LO: readdata_d = product_ext[31:0];
        ADDR_RES_HI: readdata_d = product_ext[63:32];
        default:     readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule
